// File: rtl/stack_unit.sv
// Operand stack: register-array LIFO with separate sp/count, gated tos/nos views.
// Optional boundary guarding and sticky error flags: define STACK_GUARD_EN.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_tos,
  output logic [WIDTH-1:0]         o_nos,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_sp;
  logic [CW-1:0]               r_count;

  logic          w_empty, w_full;
  logic          w_replace, w_push_req, w_pop_req;
  logic          w_push_en, w_pop_en, w_we;
  logic [AW-1:0] w_sp_m1, w_sp_m2, w_waddr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_sp_m1 = r_sp - AW'(1);
  assign w_sp_m2 = r_sp - AW'(2);

  // push+pop on an empty stack falls through to a plain push
  assign w_replace  = i_push & i_pop & ~w_empty;
  assign w_push_req = i_push & ~w_replace;
  assign w_pop_req  = i_pop & ~i_push;

`ifdef STACK_GUARD_EN
  logic r_ovf, r_unf;

  assign w_push_en = w_push_req & ~w_full;
  assign w_pop_en  = w_pop_req & ~w_empty;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push_req && w_full)  r_ovf <= 1'b1;
      if (w_pop_req  && w_empty) r_unf <= 1'b1;
    end
  end

  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;
`else
  assign w_push_en   = w_push_req;
  assign w_pop_en    = w_pop_req;
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign w_we    = w_push_en | w_replace;
  assign w_waddr = w_replace ? w_sp_m1 : r_sp;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem <= '0;
    end else if (w_we) begin
      r_mem[w_waddr] <= i_din;
    end
  end

  // unguarded wrap: sp keeps moving, count saturates at both ends
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (w_push_en) begin
      r_sp <= r_sp + AW'(1);
      if (!w_full) r_count <= r_count + CW'(1);
    end else if (w_pop_en) begin
      r_sp <= w_sp_m1;
      if (!w_empty) r_count <= r_count - CW'(1);
    end
  end

  assign o_tos   = w_empty ? '0 : r_mem[w_sp_m1];
  assign o_nos   = (r_count < CW'(2)) ? '0 : r_mem[w_sp_m2];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;
endmodule

// File: doc/stack_unit.md
# stack_unit

Operand stack for the stack-machine datapath. It sits directly downstream of the instruction controller and executes that controller's single-cycle `push`/`pop` strobes. Pushed data comes from the datapath write mux (ALU result or PC/IR immediate). The top of stack feeds the A/B operand registers and the zero test used by conditional jump.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 16, number of stack entries; power of two, minimum 2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `push`  in  1  write `din` onto the stack this cycle
- `pop`  in  1  remove the top entry this cycle
- `din`  in  WIDTH  data to push
- `tos`  out  WIDTH  current top of stack; 0 when empty
- `nos`  out  WIDTH  entry below top; 0 when count < 2
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `overflow`  out  1  sticky error flag, push rejected while full
- `underflow`  out  1  sticky error flag, pop rejected while empty

## Operation
- Storage is a register array `mem[0..DEPTH-1]`. Stack pointer `sp` is log2(DEPTH) bits and points at the next free slot.
- `count` is kept separately so that full is distinguishable from empty.
- `tos` = mem[sp-1] and `nos` = mem[sp-2], both with modulo-DEPTH index.
- `tos` and `nos` are gated to 0 by `count` as specified in the interface.
- Outputs are combinational from registered state. There is no combinational path from `push`, `pop` or `din`.
- Per-cycle action, evaluated at the rising `clk` edge:
  - Idle (push=0, pop=0): no change.
  - Push only: mem[sp] <= din; sp <= sp+1; count <= count+1.
  - Pop only: sp <= sp-1; count <= count-1. The popped entry is not cleared.
  - Push and pop together, count > 0: replace top. mem[sp-1] <= din; sp and count unchanged.
  - Push and pop together, count == 0: treated as push only. `underflow` is not set.
- Boundary behaviour is set by `STACK_GUARD_EN` (see Configuration).
- `overflow` and `underflow` clear only on reset.
- Reset (`rst`=0), asynchronous and effective mid-operation:
  - sp=0, count=0, all mem entries=0, overflow=0, underflow=0.
  - Resulting outputs: tos=0, nos=0, empty=1, full=0.
- No state machine beyond the sp/count pair. The controller guarantees strobes are single-cycle; this block does not edge-detect.

## Timing
- Push latency: 1 cycle. `din` sampled at edge N appears on `tos` after edge N.
- Pop latency: 1 cycle. The new top is visible after the edge.
- Back-to-back push/pop on consecutive cycles is fully supported, with no bubble.
- `empty`, `full` and `count` update in the same cycle as `tos`.
- Flags set on the edge where the offending operation is sampled.
- Reset assertion clears outputs immediately, with no clock required. Deassertion is synchronous to the design clock upstream.

## Configuration
- `STACK_GUARD_EN` defined:
  - Push-only while full is ignored (mem, sp, count unchanged) and sets `overflow`.
  - Pop-only while empty is ignored and sets `underflow`.
  - Replace-top while full is legal.
- `STACK_GUARD_EN` undefined:
  - No guarding; `overflow` and `underflow` are tied to 0.
  - sp wraps modulo DEPTH.
  - Push while full overwrites the oldest entry; count saturates at DEPTH.
  - Pop while empty decrements sp; count saturates at 0; tos stays 0.

## Test plan
- Reset, then push 0x05, push 0x03 -> tos=0x03, nos=0x05, count=2, empty=0. Pop -> tos=0x05, count=1.
- Hold push with din=0x00..0x0F for 16 cycles -> full=1, tos=0x0F. A 17th push of 0xAA:
  - guard on: tos=0x0F, overflow=1.
  - guard off: tos=0xAA, count=16.
- From empty, pop -> guard on: underflow=1, count=0, tos=0. Then push and pop together with din=0x11 -> tos=0x11, count=1, underflow still 1.
- With count=3 and top=0x07, push and pop together with din=0x09 -> tos=0x09, count=3, nos unchanged.
- Push 0x20, 0x21, then drive `rst` low mid-cycle with no clock edge -> immediately count=0, tos=0, flags 0. After release, push 0x01 -> tos=0x01, nos=0.
- ADD sequence as issued by the controller: push 4, push 6, then pop, pop, push 0x0A on three consecutive cycles -> tos=0x0A, count=1.
